// File: rtl/cpu_pkg.sv
// Shared types and constants for the 9-bit, 7-register multi-cycle CPU.
package cpu_pkg;

  localparam int ADDR_W   = 10;
  localparam int DATA_W   = 9;
  localparam int NUM_REGS = 7;
  localparam int CNT_W    = 16;
  localparam int INSTR_W  = 22;
  localparam int OPC_W    = 4;
  localparam int SEL_W    = 3;

  // Bit positions of the instruction fields (LSB of each field).
  localparam int OPC_LSB  = 18;
  localparam int SRCA_LSB = 15;
  localparam int SRCB_LSB = 12;
  localparam int DEST_LSB = 9;
  localparam int IMM_LSB  = 0;

  localparam logic [OPC_W-1:0] OP_MOVI = 4'd13;
  localparam logic [OPC_W-1:0] OP_NOP  = 4'd14;
  localparam logic [OPC_W-1:0] OP_HALT = 4'd15;

  // Select value one past the last register file entry; a write to it flags an illegal instruction.
  localparam logic [SEL_W-1:0] BAD_REG = SEL_W'(NUM_REGS);

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    DECODE,
    EXECUTE,
    WRITEBACK,
    HALTED
  } state_t;

  typedef struct packed {
    logic [OPC_W-1:0]  opcode;
    logic [SEL_W-1:0]  src_a;
    logic [SEL_W-1:0]  src_b;
    logic [SEL_W-1:0]  dest;
    logic [DATA_W-1:0] imm;
  } instr_t;

  // Split a raw RAM word into its named fields.
  function automatic instr_t unpack_instr(input logic [INSTR_W-1:0] word);
    instr_t ins;
    ins.opcode = word[OPC_LSB  +: OPC_W];
    ins.src_a  = word[SRCA_LSB +: SEL_W];
    ins.src_b  = word[SRCB_LSB +: SEL_W];
    ins.dest   = word[DEST_LSB +: SEL_W];
    ins.imm    = word[IMM_LSB  +: DATA_W];
    return ins;
  endfunction

endpackage

// File: rtl/cpu_sequencer_decoder.sv
// Combinational instruction decoder: IR -> datapath selects and intent flags.
module instr_decoder
  import cpu_pkg::*;
(
  input  instr_t             ir,
  output logic [OPC_W-1:0]   alu_op,
  output logic [SEL_W-1:0]   src_a_sel,
  output logic [SEL_W-1:0]   src_b_sel,
  output logic [SEL_W-1:0]   dest_sel,
  output logic [DATA_W-1:0]  imm_out,
  output logic               imm_sel,
  output logic               wr_intent,
  output logic               is_halt
);

  // Field routing and opcode classification.
  // NOTE: every output gets a default first so no path can infer a latch.
  always_comb begin
    alu_op    = '0;
    src_a_sel = ir.src_a;
    src_b_sel = ir.src_b;
    dest_sel  = ir.dest;
    imm_out   = ir.imm;
    imm_sel   = 1'b0;
    wr_intent = 1'b0;
    is_halt   = 1'b0;
    case (ir.opcode)
      OP_MOVI: begin
        imm_sel   = 1'b1;
        wr_intent = 1'b1;
      end
      OP_NOP:  ;
      OP_HALT: is_halt = 1'b1;
      default: begin
        alu_op    = ir.opcode;
        wr_intent = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/cpu_sequencer.sv
// Multi-cycle control unit: FETCH -> DECODE -> EXECUTE -> WRITEBACK per instruction.
module cpu_sequencer
  import cpu_pkg::*;
(
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  input  logic               mem_ready,
  input  logic [INSTR_W-1:0] instr_in,
  output logic [ADDR_W-1:0]  pc_out,
  output logic [OPC_W-1:0]   alu_op,
  output logic [SEL_W-1:0]   src_a_sel,
  output logic [SEL_W-1:0]   src_b_sel,
  output logic [DATA_W-1:0]  imm_out,
  output logic               imm_sel,
  output logic [SEL_W-1:0]   dest_sel,
  output logic               reg_we,
  output logic               halted,
  output logic               illegal,
  output logic [CNT_W-1:0]   retired
);

  state_t            state_q, state_d;
  instr_t            ir_q;
  logic [ADDR_W-1:0] pc_q;
  logic [CNT_W-1:0]  retired_q;
  logic              illegal_q;
  logic              reg_we_q;
  logic              wr_intent;
  logic              is_halt;
  logic              dest_ok;

  // Selects follow IR directly; IR only changes on leaving FETCH, so they are
  // stable from DECODE through WRITEBACK.
  instr_decoder u_dec (
    .ir        (ir_q),
    .alu_op    (alu_op),
    .src_a_sel (src_a_sel),
    .src_b_sel (src_b_sel),
    .dest_sel  (dest_sel),
    .imm_out   (imm_out),
    .imm_sel   (imm_sel),
    .wr_intent (wr_intent),
    .is_halt   (is_halt)
  );

  assign dest_ok = (ir_q.dest != BAD_REG);

  // State register.
  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      if (start)     state_d = FETCH;
      FETCH:     if (mem_ready) state_d = DECODE;
      DECODE:    state_d = is_halt ? HALTED : EXECUTE;
      EXECUTE:   state_d = WRITEBACK;
      WRITEBACK: state_d = FETCH;
      HALTED:    state_d = HALTED;
      default:   state_d = IDLE;
    endcase
  end

  // Datapath registers: IR, PC, retire counter, sticky illegal flag, write enable.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ir_q      <= '0;
      pc_q      <= '0;
      retired_q <= '0;
      illegal_q <= 1'b0;
      reg_we_q  <= 1'b0;
    end else begin
      // reg_we is registered so it is high for the whole WRITEBACK cycle.
      reg_we_q <= (state_q == EXECUTE) && wr_intent && dest_ok;

      if ((state_q == EXECUTE) && wr_intent && !dest_ok)
        illegal_q <= 1'b1;

      case (state_q)
        IDLE:  pc_q <= '0;
        FETCH: if (mem_ready) ir_q <= unpack_instr(instr_in);
        WRITEBACK: begin
          pc_q <= pc_q + ADDR_W'(1);
          if (retired_q != '1)
            retired_q <= retired_q + CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

  assign pc_out  = pc_q;
  assign retired = retired_q;
  assign illegal = illegal_q;
  assign reg_we  = reg_we_q;
  assign halted  = (state_q == HALTED);

endmodule

// File: tb/tb_cpu_sequencer.sv
// Directed self-checking bench for cpu_sequencer.
module tb_cpu_sequencer;
  import cpu_pkg::*;

  logic               clock = 1'b0;
  logic               reset = 1'b1;
  logic               start = 1'b0;
  logic               mem_ready = 1'b1;
  logic [INSTR_W-1:0] instr_in;
  logic [ADDR_W-1:0]  pc_out;
  logic [OPC_W-1:0]   alu_op;
  logic [SEL_W-1:0]   src_a_sel, src_b_sel, dest_sel;
  logic [DATA_W-1:0]  imm_out;
  logic               imm_sel, reg_we, halted, illegal;
  logic [CNT_W-1:0]   retired;

  logic [INSTR_W-1:0] mem [0:1023];
  assign instr_in = mem[pc_out];

  cpu_sequencer dut (
    .clock(clock), .reset(reset), .start(start), .mem_ready(mem_ready),
    .instr_in(instr_in), .pc_out(pc_out), .alu_op(alu_op),
    .src_a_sel(src_a_sel), .src_b_sel(src_b_sel), .imm_out(imm_out),
    .imm_sel(imm_sel), .dest_sel(dest_sel), .reg_we(reg_we),
    .halted(halted), .illegal(illegal), .retired(retired)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [INSTR_W-1:0] enc(input logic [3:0] op, input logic [2:0] a,
                                             input logic [2:0] b, input logic [2:0] d,
                                             input logic [8:0] imm);
    return {op, a, b, d, imm};
  endfunction

  // Write-enable capture from the most recent run.
  int               we_n;
  int               we_cyc   [8];
  logic [2:0]       we_dest  [8];
  logic             we_isel  [8];
  logic [8:0]       we_imm   [8];
  logic [3:0]       we_alu   [8];
  logic [2:0]       we_sa    [8];
  logic [2:0]       we_sb    [8];
  int               halt_cyc;
  bit               stall_ok;

  task automatic fill_nop();
    for (int i = 0; i < 1024; i++) mem[i] = enc(OP_NOP, 3'd0, 3'd0, 3'd0, 9'd0);
  endtask

  task automatic load_prog1();
    fill_nop();
    mem[0] = enc(OP_MOVI, 3'd0, 3'd0, 3'd0, 9'd5);
    mem[1] = enc(OP_MOVI, 3'd0, 3'd0, 3'd1, 9'd3);
    mem[2] = enc(4'd0,    3'd0, 3'd1, 3'd2, 9'd0);
    mem[3] = enc(OP_HALT, 3'd0, 3'd0, 3'd0, 9'd0);
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1; start = 1'b0; mem_ready = 1'b1;
    @(negedge clock);
    reset = 1'b0;
  endtask

  // Pulse start at a negedge; cycle 1 is sampled at the negedge after the start edge.
  task automatic kick();
    @(negedge clock);
    start = 1'b1;
    @(posedge clock);
    #1 start = 1'b0;
  endtask

  // Run from start until halted. mem_ready is low for cycles st_lo..st_hi,
  // start is high for cycles sp_lo..sp_hi; pc_out must equal stall_pc while stalled.
  task automatic run(input int max_cyc, input int st_lo, input int st_hi,
                     input int sp_lo, input int sp_hi, input logic [9:0] stall_pc);
    we_n = 0; halt_cyc = -1; stall_ok = 1'b1;
    kick();
    for (int c = 1; c <= max_cyc; c++) begin
      @(negedge clock);
      if (reg_we && we_n < 8) begin
        we_cyc[we_n] = c; we_dest[we_n] = dest_sel; we_isel[we_n] = imm_sel;
        we_imm[we_n] = imm_out; we_alu[we_n] = alu_op;
        we_sa[we_n] = src_a_sel; we_sb[we_n] = src_b_sel;
        we_n++;
      end
      if (c >= st_lo && c <= st_hi + 1 && pc_out != stall_pc) stall_ok = 1'b0;
      if (halted) begin
        halt_cyc = c;
        break;
      end
      mem_ready = !(c >= st_lo && c <= st_hi);
      start     = (c >= sp_lo && c <= sp_hi);
    end
    mem_ready = 1'b1; start = 1'b0;
    if (halt_cyc < 0) check("halt_timeout", 32'(halted), 32'd1);
  endtask

  initial begin
    bit seen_1023, no_we;
    // ---- reset state ----
    load_prog1();
    #12;
    check("rst_pc", 32'(pc_out), 0);
    check("rst_we", 32'(reg_we), 0);
    check("rst_halt", 32'(halted), 0);
    check("rst_ill", 32'(illegal), 0);
    check("rst_ret", 32'(retired), 0);
    check("rst_sel", 32'({alu_op, src_a_sel, src_b_sel, dest_sel, imm_out, imm_sel}), 0);
    do_reset();

    // ---- basic program, no stalls ----
    run(40, 0, -1, 0, -1, 10'd0);
    check("p1_we_n", we_n, 3);
    check("p1_we0_cyc", we_cyc[0], 4);
    check("p1_we1_cyc", we_cyc[1], 8);
    check("p1_we2_cyc", we_cyc[2], 12);
    check("p1_dests", 32'({we_dest[0], we_dest[1], we_dest[2]}), 32'({3'd0, 3'd1, 3'd2}));
    check("p1_movi_imm", 32'({we_isel[0], we_imm[0]}), 32'({1'b1, 9'd5}));
    check("p1_add_ctl", 32'({we_isel[2], we_alu[2], we_sa[2], we_sb[2]}),
          32'({1'b0, 4'd0, 3'd0, 3'd1}));
    check("p1_halt_cyc", halt_cyc, 15);
    check("p1_pc", 32'(pc_out), 3);
    check("p1_ret", 32'(retired), 3);
    // start while halted must do nothing
    @(negedge clock); start = 1'b1;
    repeat (3) @(negedge clock);
    start = 1'b0;
    @(negedge clock);
    check("halt_start", 32'({halted, pc_out, retired}), 32'({1'b1, 10'd3, 16'd3}));

    // ---- stall on second fetch, start pulsed during that fetch ----
    do_reset();
    run(60, 5, 9, 5, 7, 10'd1);
    check("st_pc_hold", 32'(stall_ok), 1);
    check("st_we_cyc", 32'({8'(we_cyc[0]), 8'(we_cyc[1]), 8'(we_cyc[2])}),
          32'({8'd4, 8'd13, 8'd17}));
    check("st_dests", 32'({we_dest[0], we_dest[1], we_dest[2]}), 32'({3'd0, 3'd1, 3'd2}));
    check("st_end", 32'({8'(halt_cyc), pc_out, retired[7:0]}), 32'({8'd20, 10'd3, 8'd3}));

    // ---- ALU op, then MOVI to r7, then HALT ----
    fill_nop();
    mem[0] = enc(4'd5,    3'd4, 3'd5, 3'd3, 9'd0);
    mem[1] = enc(OP_MOVI, 3'd0, 3'd0, 3'd7, 9'h1FF);
    mem[2] = enc(OP_HALT, 3'd0, 3'd0, 3'd0, 9'd0);
    do_reset();
    run(40, 0, -1, 0, -1, 10'd0);
    check("il_we_n", we_n, 1);
    check("il_alu_ctl", 32'({we_dest[0], we_alu[0], we_sa[0], we_sb[0], we_isel[0]}),
          32'({3'd3, 4'd5, 3'd4, 3'd5, 1'b0}));
    check("il_flag", 32'({illegal, halted}), 32'({1'b1, 1'b1}));
    check("il_pc_ret", 32'({pc_out, retired}), 32'({10'd2, 16'd2}));

    // ---- asynchronous reset during WRITEBACK of the first instruction ----
    load_prog1();
    do_reset();
    kick();
    repeat (4) @(negedge clock);
    check("ar_we_pre", 32'(reg_we), 1);
    #2 reset = 1'b1;
    #1 check("ar_we_async", 32'(reg_we), 0);
    @(negedge clock); reset = 1'b0;

    // ---- asynchronous reset during EXECUTE of the third instruction ----
    kick();
    repeat (11) @(negedge clock);
    check("ar3_pre", 32'({pc_out, retired}), 32'({10'd2, 16'd2}));
    #2 reset = 1'b1;
    #1 check("ar3_async", 32'({pc_out, retired, reg_we}), 0);
    @(negedge clock); reset = 1'b0;
    no_we = 1'b1;
    repeat (6) begin
      @(negedge clock);
      if (reg_we || halted || pc_out != 10'd0) no_we = 1'b0;
    end
    check("ar3_idle", 32'(no_we), 1);
    run(40, 0, -1, 0, -1, 10'd0);
    check("ar3_rerun", 32'({8'(halt_cyc), 8'(we_n), retired[7:0]}),
          32'({8'd15, 8'd3, 8'd3}));

    // ---- PC wrap from 1023 to 0 ----
    fill_nop();
    do_reset();
    kick();
    seen_1023 = 1'b0;
    for (int c = 1; c <= 4400; c++) begin
      @(negedge clock);
      if (pc_out == 10'd1023) seen_1023 = 1'b1;
      if (pc_out == 10'd8) mem[0] = enc(OP_HALT, 3'd0, 3'd0, 3'd0, 9'd0);
      if (halted) break;
    end
    check("wr_seen1023", 32'(seen_1023), 1);
    check("wr_end", 32'({halted, pc_out, retired}), 32'({1'b1, 10'd0, 16'd1024}));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
